multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port.
- Drives ALUOp, branch and Jlink into the ALU decoder, and takes back its PC-select result.
- Sits beside the ALU decoder in the CPU top level and owns every datapath mux select and write enable.

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_out_decode.sv | 93 +++++++++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State enum, opcode values, mux-select codes and the control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_MEM   = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
    logic       jlink;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-bundle decode from the FSM state.
// Only FETCH and BRANCH qualify their PC/IR loads by mem_ready/pcsrc.
import ctrl_pkg::*;

module ctrl_out_decode (
  input  state_t state,
  input  logic   mem_ready,
  input  logic   pcsrc,
  output ctrl_t  ctrl
);

  // Per-state datapath selects; anything unlisted stays 0
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_MEM;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = ADR_ALUOUT;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = pcsrc;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.jlink      = 1'b1;
        ctrl.pc_write   = 1'b1;
      end
      S_HALT: begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core with memory timeout.
// Define PERF_CNT_EN to add cycle and retired-instruction counters.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             pcsrc,
  output logic             mem_req_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             AdrSrc_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       ResultSrc_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             Branch_o,
  output logic             Jlink_o,
  output logic             halt_o,
  output logic             bus_err_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
`endif
);

  localparam int unsigned WCNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic              waiting;
  logic              timeout;
  ctrl_t             ctrl;

  // Next state, wait-state counter and sticky bus-error flag
  always_comb begin
    waiting = ((state_q == S_FETCH) ||
               (state_q == S_MEMREAD) ||
               (state_q == S_MEMWRITE)) && !mem_ready;
    timeout = TO_EN && waiting && (wait_q == WAIT_LAST);
    state_d = state_q;
    unique case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_HALT;
        endcase
      end
      S_MEMADR:
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    if (timeout) state_d = S_HALT;
    wait_d = '0;
    if (TO_EN && waiting && (state_d == state_q)) begin
      wait_d = wait_q + WCNT_W'(1);
    end
    bus_err_d = bus_err_q | timeout;
  end

  // State, wait counter and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  ctrl_out_decode u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .pcsrc     (pcsrc),
    .ctrl      (ctrl)
  );

  assign mem_req_o   = ctrl.mem_req;
  assign IRWrite_o   = ctrl.ir_write;
  assign PCWrite_o   = ctrl.pc_write;
  assign AdrSrc_o    = ctrl.adr_src;
  assign MemWrite_o  = ctrl.mem_write;
  assign RegWrite_o  = ctrl.reg_write;
  assign ResultSrc_o = ctrl.result_src;
  assign ALUSrcA_o   = ctrl.alu_src_a;
  assign ALUSrcB_o   = ctrl.alu_src_b;
  assign ALUOp_o     = ctrl.alu_op;
  assign Branch_o    = ctrl.branch;
  assign Jlink_o     = ctrl.jlink;
  assign halt_o      = ctrl.halt;
  assign bus_err_o   = bus_err_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  // Run-cycle count and retirement on every re-entry to FETCH
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if ((state_q != S_RST) && (state_q != S_HALT)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if ((state_d == S_FETCH) && (state_q != S_FETCH) &&
        (state_q != S_RST)) begin
      ret_d = ret_q + CNT_W'(1);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_cnt_o   = cyc_q;
  assign instret_cnt_o = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Per-instruction cycle plans are built from the instruction-class rules.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_LUI    = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pcsrc = 1'b0;
  logic       mem_req_o, IRWrite_o, PCWrite_o, AdrSrc_o;
  logic       MemWrite_o, RegWrite_o;
  logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o;
  logic       Branch_o, Jlink_o, halt_o, bus_err_o;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcsrc       (pcsrc),
    .mem_req_o   (mem_req_o),
    .IRWrite_o   (IRWrite_o),
    .PCWrite_o   (PCWrite_o),
    .AdrSrc_o    (AdrSrc_o),
    .MemWrite_o  (MemWrite_o),
    .RegWrite_o  (RegWrite_o),
    .ResultSrc_o (ResultSrc_o),
    .ALUSrcA_o   (ALUSrcA_o),
    .ALUSrcB_o   (ALUSrcB_o),
    .ALUOp_o     (ALUOp_o),
    .Branch_o    (Branch_o),
    .Jlink_o     (Jlink_o),
    .halt_o      (halt_o),
    .bus_err_o   (bus_err_o)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt_o   (cyc_cnt),
    .instret_cnt_o (ins_cnt)
`endif
  );

  typedef struct packed {
    logic       mreq;
    logic       irw;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       br;
    logic       jl;
    logic       halt;
    logic       berr;
  } out_t;

  typedef struct {
    logic  rdy;
    logic  pc;
    out_t  exp;
    string nm;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    bit         pc;
    int         rw;
    int         pcw;
  } vec_t;

  out_t dut_o;
  assign dut_o = {mem_req_o, IRWrite_o, PCWrite_o, AdrSrc_o,
                  MemWrite_o, RegWrite_o, ResultSrc_o,
                  ALUSrcA_o, ALUSrcB_o, ALUOp_o,
                  Branch_o, Jlink_o, halt_o, bus_err_o};

  cyc_t q[$];
  vec_t tbl[10];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic out_t v(
    bit mreq, bit irw, bit pcw, bit adr, bit mw, bit rw,
    logic [1:0] res, logic [1:0] a, logic [1:0] b,
    logic [1:0] op, bit br, bit jl);
    out_t o;
    o = '0;
    o.mreq = mreq; o.irw = irw; o.pcw = pcw;
    o.adr = adr; o.mw = mw; o.rw = rw;
    o.res = res; o.a = a; o.b = b; o.op = op;
    o.br = br; o.jl = jl;
    return o;
  endfunction

  function automatic out_t hv(bit berr);
    out_t o;
    o = '0;
    o.halt = 1'b1;
    o.berr = berr;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic push(logic rdy, logic pc, out_t e, string nm);
    cyc_t c;
    c.rdy = rdy; c.pc = pc; c.exp = e; c.nm = nm;
    q.push_back(c);
  endtask

  task automatic chk(string nm, out_t got, out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected cycles of one instruction, from the per-class phase rules
  task automatic plan(logic [6:0] op, int fw, int mw, bit pc);
    out_t fwt, fdone, dec, mad, mrd, mwr, mwb;
    out_t exr, exi, lui, awb, brc, jal;
    int   n;
    fwt   = v(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
    fdone = v(1,1,1,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
    dec   = v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0);
    mad   = v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,0,0);
    mrd   = v(1,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
    mwr   = v(1,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0);
    mwb   = v(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0,0);
    exr   = v(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
    exi   = v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0);
    lui   = v(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0,0);
    awb   = v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0);
    brc   = v(0,0,pc,0,0,0,2'b00,2'b10,2'b00,2'b01,1,0);
    jal   = v(0,0,1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,1);
    n = (fw < TO) ? fw : TO;
    for (int i = 0; i < n; i++) push(0, rnd(), fwt, "fetch_wait");
    if (fw >= TO) begin
      for (int i = 0; i < 3; i++) push(rnd(), rnd(), hv(1), "fetch_tmo");
      return;
    end
    push(1, rnd(), fdone, "fetch");
    push(rnd(), rnd(), dec, "decode");
    case (op)
      T_LOAD, T_STORE: begin
        push(rnd(), rnd(), mad, "memadr");
        n = (mw < TO) ? mw : TO;
        for (int i = 0; i < n; i++)
          push(0, rnd(), (op == T_STORE) ? mwr : mrd, "mem_wait");
        if (mw >= TO) begin
          for (int i = 0; i < 3; i++) push(rnd(), rnd(), hv(1), "mem_tmo");
          return;
        end
        push(1, rnd(), (op == T_STORE) ? mwr : mrd, "mem_done");
        if (op == T_LOAD) push(rnd(), rnd(), mwb, "memwb");
      end
      T_RTYPE: begin
        push(rnd(), rnd(), exr, "execr");
        push(rnd(), rnd(), awb, "aluwb");
      end
      T_ITYPE: begin
        push(rnd(), rnd(), exi, "execi");
        push(rnd(), rnd(), awb, "aluwb");
      end
      T_LUI: begin
        push(rnd(), rnd(), lui, "lui");
        push(rnd(), rnd(), awb, "aluwb");
      end
      T_BRANCH: push(rnd(), pc, brc, "branch");
      T_JAL: begin
        push(rnd(), rnd(), jal, "jal");
        push(rnd(), rnd(), awb, "jal_wb");
      end
      default: begin
        for (int i = 0; i < 20; i++) push(rnd(), rnd(), hv(0), "halt");
      end
    endcase
  endtask

  task automatic run_plan(logic [6:0] op, output int rw_n,
                          output int pcw_n);
    cyc_t c;
    opcode = op;
    rw_n = 0;
    pcw_n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy;
      pcsrc = c.pc;
      #1;
      chk(c.nm, dut_o, c.exp);
      rw_n += int'(RegWrite_o);
      pcw_n += int'(PCWrite_o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", dut_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_idle", dut_o, '0);
  endtask

  initial begin
    int rw_n, pcw_n;
    logic [6:0] ops [7];
    out_t mwr;
    tbl[0] = '{T_RTYPE,  0, 0, 0, 1, 1};
    tbl[1] = '{T_LOAD,   0, 3, 0, 1, 1};
    tbl[2] = '{T_BRANCH, 0, 0, 1, 0, 2};
    tbl[3] = '{T_BRANCH, 1, 0, 0, 0, 1};
    tbl[4] = '{T_STORE,  2, 1, 0, 0, 1};
    tbl[5] = '{T_ITYPE,  3, 0, 0, 1, 1};
    tbl[6] = '{T_LUI,    0, 0, 0, 1, 1};
    tbl[7] = '{T_JAL,    0, 0, 0, 1, 2};
    tbl[8] = '{T_LOAD,   3, 3, 1, 1, 1};
    tbl[9] = '{T_STORE,  0, 0, 1, 0, 1};
    ops = '{T_LOAD, T_STORE, T_RTYPE, T_ITYPE,
            T_BRANCH, T_JAL, T_LUI};

    repeat (2) @(negedge clk);
    #1;
    chk("reset", dut_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", dut_o, '0);

    for (int i = 0; i < 10; i++) begin
      plan(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].pc);
      run_plan(tbl[i].op, rw_n, pcw_n);
      chk_int($sformatf("tbl%0d_regwrite", i), rw_n, tbl[i].rw);
      chk_int($sformatf("tbl%0d_pcwrite", i), pcw_n, tbl[i].pcw);
    end

    plan(7'b0000000, 0, 0, 0);
    run_plan(7'b0000000, rw_n, pcw_n);
    do_reset();

    plan(T_RTYPE, TO, 0, 0);
    run_plan(T_RTYPE, rw_n, pcw_n);
    do_reset();

    plan(T_LOAD, 0, TO, 0);
    run_plan(T_LOAD, rw_n, pcw_n);
    do_reset();

    plan(T_STORE, 1, TO, 0);
    run_plan(T_STORE, rw_n, pcw_n);
    do_reset();

    mwr = v(1,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0);
    plan(T_STORE, 0, 0, 0);
    void'(q.pop_back());
    push(0, 0, mwr, "mw_hold");
    push(0, 0, mwr, "mw_hold");
    run_plan(T_STORE, rw_n, pcw_n);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", dut_o, '0);
    @(negedge clk);
    #1;
    chk("rst_mid_hold", dut_o, '0);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_release", dut_o, '0);
    plan(T_RTYPE, 3, 0, 0);
    run_plan(T_RTYPE, rw_n, pcw_n);
    chk_int("after_rst_regwrite", rw_n, 1);

    for (int i = 0; i < 150; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 6)];
      plan(op, $urandom_range(0, TO - 1),
           $urandom_range(0, TO - 1), 1'($urandom));
      run_plan(op, rw_n, pcw_n);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
